sgd_update: RTL and testbench

- Downstream consumer of the linear bias/weight gradient stage.
- Applies one plain SGD step over a parameter region in memory, p[i] <- p[i] - lr*g[i], using the gradient region that the gradient stage wrote.
- Walks both regions element by element through two mem_handle ports and writes each updated parameter back in place.
- Uses the same go/done handshake as the other fpu-layer op blocks, so the op scheduler can chain it directly after the gradient stage.

---
 rtl/sgd_update_pkg.sv | 38 +++
 rtl/sgd_fx_step.sv | 37 +++
 rtl/sgd_update.sv | 215 +++++++++++++++++++++
 tb/tb_sgd_update.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_update_pkg.sv
// Shared definitions for the SGD update block: FSM states, fixed-point
// limits and the request/response payloads of a memory handle.
package sgd_update_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned FX_FRAC = 16;

    localparam logic [DATA_W-1:0] FX_MAX = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] FX_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        RD_G,
        RD_P,
        CALC,
        WR_P,
        DONE
    } state_t;

    // Block -> memory side of a handle.
    typedef struct packed {
        logic              r_en;
        logic              w_en;
        logic              avail;
        logic              write_through;
        logic [ADDR_W-1:0] ptr;
        logic [DATA_W-1:0] data_store;
    } mem_req_t;

    // Memory -> block side of a handle.
    typedef struct packed {
        logic [DATA_W-1:0] data_load;
        logic              done;
    } mem_rsp_t;

endpackage

// File: rtl/sgd_fx_step.sv
// One saturating fixed-point SGD step: result = sat32(p - ((lr * g) >>> FRAC_BITS)).
// Ports: p, g, lr (signed Q15.16 words) in; result word and overflow flag out.
module sgd_fx_step #(
    parameter int unsigned FRAC_BITS = 16
) (
    input  logic [31:0] p,
    input  logic [31:0] g,
    input  logic [31:0] lr,
    output logic [31:0] result,
    output logic        ovf
);

    localparam logic signed [48:0] DIFF_MAX = 49'sd2147483647;
    localparam logic signed [48:0] DIFF_MIN = -49'sd2147483648;

    logic signed [63:0] prod;
    logic signed [48:0] step;
    logic signed [48:0] diff;

    // 49 bits holds sext(p) minus any 48-bit shifted product without wrap.
    always_comb begin
        prod = 64'($signed(lr)) * 64'($signed(g));
        step = 49'(prod >>> FRAC_BITS);
        diff = 49'($signed(p)) - step;
        if (diff > DIFF_MAX) begin
            result = 32'h7FFF_FFFF;
            ovf    = 1'b1;
        end else if (diff < DIFF_MIN) begin
            result = 32'h8000_0000;
            ovf    = 1'b1;
        end else begin
            result = diff[31:0];
            ovf    = 1'b0;
        end
    end

endmodule

// File: rtl/sgd_update.sv
// Applies p[i] <- p[i] - lr*g[i] over a parameter region, reading the gradient
// region and writing each updated parameter back in place.
// Ports: clk, rst_l (sync, active-high); g/p memory handles (req out, rsp in,
// region bounds in); lr, go in; done, busy, sat, count out.
module sgd_update
    import sgd_update_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FX_FRAC,
    parameter logic [31:0] LR_RESET  = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [ADDR_W-1:0] g_region_begin,
    input  logic [ADDR_W-1:0] g_region_end,
    input  mem_rsp_t          g_rsp,
    output mem_req_t          g_req,
    input  logic [ADDR_W-1:0] p_region_begin,
    input  mem_rsp_t          p_rsp,
    output mem_req_t          p_req,
    input  logic [31:0]       lr,
    input  logic              go,
    output logic              done,
    output logic              busy,
    output logic              sat,
    output logic [CNT_W-1:0]  count
);

    state_t            state_q, state_d;
    logic [31:0]       lr_q, lr_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [31:0]       grad_q, grad_d;
    logic [31:0]       par_q, par_d;
    logic [31:0]       new_q, new_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              g_r_en_q, g_r_en_d, g_avail_q, g_avail_d;
    logic [ADDR_W-1:0] g_ptr_q, g_ptr_d;
    logic              p_r_en_q, p_r_en_d, p_w_en_q, p_w_en_d;
    logic              p_avail_q, p_avail_d, p_wt_q, p_wt_d;
    logic [ADDR_W-1:0] p_ptr_q, p_ptr_d;

    logic [31:0]       step_res_c;
    logic              step_ovf_c;
    logic [CNT_W-1:0]  n_c;
    logic              last_c;

    sgd_fx_step #(.FRAC_BITS(FRAC_BITS)) u_step (
        .p      (par_q),
        .g      (grad_q),
        .lr     (lr_q),
        .result (step_res_c),
        .ovf    (step_ovf_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        lr_d      = lr_q;
        n_d       = n_q;
        grad_d    = grad_q;
        par_d     = par_q;
        new_d     = new_q;
        sat_d     = sat_q;
        count_d   = count_q;
        g_r_en_d  = g_r_en_q;
        g_avail_d = g_avail_q;
        g_ptr_d   = g_ptr_q;
        p_r_en_d  = p_r_en_q;
        p_w_en_d  = p_w_en_q;
        p_avail_d = p_avail_q;
        p_wt_d    = p_wt_q;
        p_ptr_d   = p_ptr_q;
        n_c       = g_region_end - g_region_begin;
        last_c    = (count_q == n_q - CNT_W'(1));

        case (state_q)
            IDLE: begin
                if (go) begin
                    lr_d    = lr;
                    n_d     = n_c;
                    g_ptr_d = g_region_begin;
                    p_ptr_d = p_region_begin;
                    sat_d   = 1'b0;
                    count_d = '0;
                    if (n_c == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = RD_G;
                        g_r_en_d  = 1'b1;
                        g_avail_d = 1'b1;
                    end
                end
            end
            RD_G: begin
                if (g_rsp.done) begin
                    grad_d    = g_rsp.data_load;
                    g_ptr_d   = g_ptr_q + ADDR_W'(1);
                    g_r_en_d  = 1'b0;
                    g_avail_d = 1'b0;
                    p_r_en_d  = 1'b1;
                    p_avail_d = 1'b1;
                    state_d   = RD_P;
                end
            end
            RD_P: begin
                if (p_rsp.done) begin
                    par_d     = p_rsp.data_load;
                    p_r_en_d  = 1'b0;
                    p_avail_d = 1'b0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                new_d     = step_res_c;
                sat_d     = sat_q | step_ovf_c;
                p_w_en_d  = 1'b1;
                p_avail_d = 1'b1;
                // count_q is the element index, so this is ptr == begin + N - 1.
                p_wt_d    = last_c;
                state_d   = WR_P;
            end
            WR_P: begin
                if (p_rsp.done) begin
                    p_w_en_d  = 1'b0;
                    p_avail_d = 1'b0;
                    p_wt_d    = 1'b0;
                    p_ptr_d   = p_ptr_q + ADDR_W'(1);
                    count_d   = count_q + CNT_W'(1);
                    if (last_c) begin
                        state_d = DONE;
                    end else begin
                        g_r_en_d  = 1'b1;
                        g_avail_d = 1'b1;
                        state_d   = RD_G;
                    end
                end
            end
            DONE: begin
                if (!go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    // State and output registers; synchronous reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst_l) begin
            state_q   <= IDLE;
            lr_q      <= LR_RESET;
            n_q       <= '0;
            grad_q    <= '0;
            par_q     <= '0;
            new_q     <= '0;
            sat_q     <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            g_r_en_q  <= 1'b0;
            g_avail_q <= 1'b0;
            g_ptr_q   <= '0;
            p_r_en_q  <= 1'b0;
            p_w_en_q  <= 1'b0;
            p_avail_q <= 1'b0;
            p_wt_q    <= 1'b0;
            p_ptr_q   <= '0;
        end else begin
            state_q   <= state_d;
            lr_q      <= lr_d;
            n_q       <= n_d;
            grad_q    <= grad_d;
            par_q     <= par_d;
            new_q     <= new_d;
            sat_q     <= sat_d;
            count_q   <= count_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            g_r_en_q  <= g_r_en_d;
            g_avail_q <= g_avail_d;
            g_ptr_q   <= g_ptr_d;
            p_r_en_q  <= p_r_en_d;
            p_w_en_q  <= p_w_en_d;
            p_avail_q <= p_avail_d;
            p_wt_q    <= p_wt_d;
            p_ptr_q   <= p_ptr_d;
        end
    end

    // Pack registered handle fields; the gradient handle never writes.
    always_comb begin
        g_req               = '0;
        g_req.r_en          = g_r_en_q;
        g_req.avail         = g_avail_q;
        g_req.ptr           = g_ptr_q;
        p_req               = '0;
        p_req.r_en          = p_r_en_q;
        p_req.w_en          = p_w_en_q;
        p_req.avail         = p_avail_q;
        p_req.write_through = p_wt_q;
        p_req.ptr           = p_ptr_q;
        p_req.data_store    = new_q;
    end

    assign done  = done_q;
    assign busy  = busy_q;
    assign sat   = sat_q;
    assign count = count_q;

endmodule

// File: tb/tb_sgd_update.sv
// Scoreboard bench for sgd_update: memory models with random latency, a
// longint reference model for the SGD step, and monitors that pop expectations.
module tb_sgd_update;
    import sgd_update_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic [15:0] g_begin = '0, g_end = '0, p_begin = '0;
    mem_req_t    g_req, p_req;
    mem_rsp_t    g_rsp = '0, p_rsp = '0;
    logic [31:0] lr = '0;
    logic        go = 1'b0;
    logic        done, busy, sat;
    logic [15:0] count;

    always #5 clk = ~clk;

    sgd_update #(.FRAC_BITS(16), .LR_RESET(32'h0000_0000)) dut (
        .clk(clk), .rst_l(rst_l),
        .g_region_begin(g_begin), .g_region_end(g_end), .g_rsp(g_rsp), .g_req(g_req),
        .p_region_begin(p_begin), .p_rsp(p_rsp), .p_req(p_req),
        .lr(lr), .go(go), .done(done), .busy(busy), .sat(sat), .count(count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct { logic [15:0] addr; logic [31:0] data; logic wt; } wr_t;
    typedef struct { logic [15:0] cnt; logic sat; } fin_t;
    wr_t  exp_wr_q[$];
    fin_t exp_fin_q[$];

    logic [31:0] g_mem[256];
    logic [31:0] p_mem[256];
    logic [31:0] gv[16], pv[16], ep[16];
    int lat_min = 0, lat_max = 0;
    int req_seen = 0;

    // Reference: p - (lr*g >> 16), saturated to signed 32 bits; bit 32 is overflow.
    function automatic logic [32:0] ref_step(input logic [31:0] pw, input logic [31:0] gw,
                                             input logic [31:0] lw);
        longint prod, stp, d;
        prod = longint'($signed(lw)) * longint'($signed(gw));
        stp  = prod >>> 16;
        d    = longint'($signed(pw)) - stp;
        if (d > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (d < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, d[31:0]};
    endfunction

    // Gradient memory: read-only, latency in [lat_min, lat_max].
    int          g_cnt = 0, g_lat = 0;
    logic [15:0] g_hold;
    always @(negedge clk) begin
        if (g_req.avail || p_req.avail) req_seen++;
        if (g_rsp.done) begin
            g_rsp.done = 1'b0;
            g_cnt = 0;
        end else if (g_req.avail && g_req.r_en) begin
            if (g_cnt == 0) begin
                g_lat  = $urandom_range(lat_max, lat_min);
                g_hold = g_req.ptr;
            end else begin
                chk("g_stall_ptr", 64'(g_req.ptr), 64'(g_hold));
            end
            if (g_cnt == g_lat) begin
                g_rsp.data_load = g_mem[g_req.ptr[7:0]];
                g_rsp.done = 1'b1;
            end else begin
                g_cnt++;
            end
        end else begin
            g_cnt = 0;
        end
    end

    // Parameter memory: reads and writes; each completed write is scored.
    int          p_cnt = 0, p_lat = 0;
    logic [51:0] p_hold;
    always @(negedge clk) begin
        if (p_rsp.done) begin
            p_rsp.done = 1'b0;
            p_cnt = 0;
        end else if (p_req.avail && (p_req.r_en || p_req.w_en)) begin
            if (p_cnt == 0) begin
                p_lat  = $urandom_range(lat_max, lat_min);
                p_hold = p_req;
            end else begin
                chk("p_stall_req", 64'(p_req), 64'(p_hold));
            end
            if (p_cnt == p_lat) begin
                if (p_req.w_en) begin
                    p_mem[p_req.ptr[7:0]] = p_req.data_store;
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write", 64'(p_req.ptr), 64'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = exp_wr_q.pop_front();
                        chk("wr_addr", 64'(p_req.ptr), 64'(e.addr));
                        chk("wr_data", 64'(p_req.data_store), 64'(e.data));
                        chk("wr_through", 64'(p_req.write_through), 64'(e.wt));
                    end
                end else begin
                    p_rsp.data_load = p_mem[p_req.ptr[7:0]];
                end
                p_rsp.done = 1'b1;
            end else begin
                p_cnt++;
            end
        end else begin
            p_cnt = 0;
        end
    end

    // Completion monitor: checks count/sat/busy on each rising done.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (exp_fin_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                fin_t f;
                f = exp_fin_q.pop_front();
                chk("fin_count", 64'(count), 64'(f.cnt));
                chk("fin_sat", 64'(sat), 64'(f.sat));
                chk("fin_busy", 64'(busy), 64'(0));
            end
        end
        done_prev = done;
    end

    // Load memories, push expectations, run one op and check the final region.
    task automatic run_op(input logic [31:0] lrv, input int n, input int gb, input int pb,
                          input int lmin, input int lmax, input int hold);
        logic [32:0] r;
        logic        s;
        int          seen;
        bit          ok;
        lat_min = lmin;
        lat_max = lmax;
        g_begin = 16'(gb);
        g_end   = 16'(gb + n);
        p_begin = 16'(pb);
        s = 1'b0;
        for (int i = 0; i < n; i++) begin
            g_mem[gb + i] = gv[i];
            p_mem[pb + i] = pv[i];
            r = ref_step(pv[i], gv[i], lrv);
            ep[i] = r[31:0];
            s = s | r[32];
            exp_wr_q.push_back('{addr: 16'(pb + i), data: r[31:0], wt: (i == n - 1)});
        end
        exp_fin_q.push_back('{cnt: 16'(n), sat: s});
        @(negedge clk);
        lr = lrv;
        go = 1'b1;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 64'(0), 64'(1));
        for (int i = 0; i < n; i++) chk("p_final", 64'(p_mem[pb + i]), 64'(ep[i]));
        seen = req_seen;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_done", 64'(done), 64'(1));
        end
        if (hold > 0) chk("hold_no_req", 64'(req_seen), 64'(seen));
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_done", 64'(done), 64'(0));
    endtask

    initial begin
        logic [17:0] t;
        int          seen;
        bit          ok;

        // Reset state
        repeat (3) @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sat", 64'(sat), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_p_req", 64'(p_req), 64'(0));
        chk("rst_g_req", 64'(g_req), 64'(0));

        // Basic: 1.0 - 0.5*2.0 = 0
        gv[0] = 32'h0002_0000;
        pv[0] = 32'h0001_0000;
        run_op(32'h0000_8000, 1, 4, 40, 0, 0, 0);
        chk("basic_value", 64'(p_mem[40]), 64'(0));

        // Vector of four
        for (int i = 0; i < 4; i++) begin
            gv[i] = 32'((i + 1) << 16);
            pv[i] = 32'h000A_0000;
        end
        run_op(32'h0001_0000, 4, 10, 50, 0, 0, 0);
        chk("vec_last", 64'(p_mem[53]), 64'(32'h0006_0000));

        // Saturation, then a clean run clears sat
        gv[0] = 32'hFFFF_0000;
        pv[0] = 32'h7FFF_0000;
        run_op(32'h0002_0000, 1, 20, 60, 0, 0, 0);
        chk("sat_value", 64'(p_mem[60]), 64'(32'h7FFF_FFFF));
        gv[0] = 32'h0001_0000;
        pv[0] = 32'h0003_0000;
        run_op(32'h0001_0000, 1, 20, 60, 0, 0, 0);

        // Empty region: done one cycle after go, no request
        g_begin = 16'd5;
        g_end   = 16'd5;
        exp_fin_q.push_back('{cnt: 16'd0, sat: 1'b0});
        seen = req_seen;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        chk("empty_done", 64'(done), 64'(1));
        chk("empty_count", 64'(count), 64'(0));
        @(negedge clk);
        chk("empty_no_req", 64'(req_seen), 64'(seen));
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Random data with random 0-7 cycle stalls
        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(16, 1);
            for (int i = 0; i < n; i++) begin
                if (k[0]) begin
                    gv[i] = $urandom;
                    pv[i] = $urandom;
                end else begin
                    t = 18'($urandom);
                    gv[i] = {{14{t[17]}}, t};
                    t = 18'($urandom);
                    pv[i] = {{14{t[17]}}, t} <<< 8;
                end
            end
            run_op(k[0] ? $urandom : 32'($urandom_range(32'h0002_0000, 0)),
                   n, $urandom_range(100, 0), $urandom_range(200, 120), 0, 7, 0);
        end

        // Reset in WR_P of element 2 of 4
        for (int i = 0; i < 4; i++) begin
            gv[i] = 32'h0001_0000;
            pv[i] = 32'h0010_0000 + 32'(i);
            g_mem[30 + i] = gv[i];
            p_mem[70 + i] = pv[i];
        end
        for (int i = 0; i < 2; i++)
            exp_wr_q.push_back('{addr: 16'(70 + i), data: pv[i] - 32'h0001_0000, wt: 1'b0});
        lat_min = 4;
        lat_max = 4;
        g_begin = 16'd30;
        g_end   = 16'd34;
        p_begin = 16'd70;
        @(negedge clk);
        lr = 32'h0001_0000;
        go = 1'b1;
        ok = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (p_req.w_en && p_req.ptr == 16'd72) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("rst_wait_timeout", 64'(0), 64'(1));
        rst_l = 1'b1;
        go = 1'b0;
        @(negedge clk);
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_sat", 64'(sat), 64'(0));
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_p_req", 64'(p_req), 64'(0));
        chk("midrst_g_req", 64'(g_req), 64'(0));
        rst_l = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_p2", 64'(p_mem[72]), 64'(pv[2]));
        chk("midrst_p3", 64'(p_mem[73]), 64'(pv[3]));
        chk("midrst_p1", 64'(p_mem[71]), 64'(pv[1] - 32'h0001_0000));
        chk("midrst_wr_left", 64'(exp_wr_q.size()), 64'(0));

        // Fresh run after reset, go held high past done
        for (int i = 0; i < 3; i++) begin
            gv[i] = 32'hFFFE_0000;
            pv[i] = 32'(i) << 16;
        end
        run_op(32'h0000_4000, 3, 30, 80, 0, 2, 8);

        chk("end_wr_q", 64'(exp_wr_q.size()), 64'(0));
        chk("end_fin_q", 64'(exp_fin_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
